sev_seg_scanner: RTL

Time-multiplexed driver for the board's 4-digit seven-segment display. It sits directly downstream of the Niski core's display register path and directly upstream of the SEVSEG_SEG_PINS / SEVSEG_SEL_PINS board pins. It holds a 16-bit hex value and a per-digit enable mask, and decodes each nibble to segments. It scans the digits with an inter-digit blanking gap, and commits new values only at frame boundaries so the display never tears.

---
 rtl/sev_seg_scanner.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sev_seg_scanner.sv
// Four-digit multiplexed seven-segment driver with per-slot blanking
// and frame-synchronous commit of the displayed value.
module sev_seg_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_mask,
    output logic [15:0] rd_data,
    output logic [6:0]  segments,
    output logic [3:0]  select,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic [3:0]    pend_mask_q, pend_mask_d;
    logic          pend_vld_q, pend_vld_d;
    logic [15:0]   disp_val_q, disp_val_d;
    logic [3:0]    disp_mask_q, disp_mask_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    sel_q, sel_d;
    logic          fd_q, fd_d;

    logic          wrap;
    logic          commit;
    logic          lit;
    logic [3:0]    nib;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        pend_val_d  = pend_val_q;
        pend_mask_d = pend_mask_q;
        pend_vld_d  = pend_vld_q;
        disp_val_d  = disp_val_q;
        disp_mask_d = disp_mask_q;
        sel_d       = 4'hF;
        seg_d       = 7'h7F;

        wrap   = (cnt_q == CNT_MAX);
        commit = wrap && (slot_q == 2'd3);

        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        slot_d = wrap ? slot_q + 2'd1 : slot_q;

        if (wr_en) begin
            pend_val_d  = wr_data;
            pend_mask_d = wr_mask;
        end

        // A write landing on the commit edge bypasses pending entirely
        if (commit) begin
            pend_vld_d = 1'b0;
            if (wr_en) begin
                disp_val_d  = wr_data;
                disp_mask_d = wr_mask;
            end else if (pend_vld_q) begin
                disp_val_d  = pend_val_q;
                disp_mask_d = pend_mask_q;
            end
        end else if (wr_en) begin
            pend_vld_d = 1'b1;
        end

        // Pins are registered, so they are computed from next-cycle state
        nib = 4'(disp_val_d >> {slot_d, 2'b00});
        lit = (cnt_d >= BLANK) && disp_mask_d[slot_d];
        if (lit) begin
            sel_d = ~(4'b0001 << slot_d);
            seg_d = decode(nib);
        end

        fd_d = (slot_d == 2'd3) && (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            slot_q      <= 2'd0;
            pend_val_q  <= 16'h0000;
            pend_mask_q <= 4'hF;
            pend_vld_q  <= 1'b0;
            disp_val_q  <= 16'h0000;
            disp_mask_q <= 4'hF;
            seg_q       <= 7'h7F;
            sel_q       <= 4'hF;
            fd_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            pend_val_q  <= pend_val_d;
            pend_mask_q <= pend_mask_d;
            pend_vld_q  <= pend_vld_d;
            disp_val_q  <= disp_val_d;
            disp_mask_q <= disp_mask_d;
            seg_q       <= seg_d;
            sel_q       <= sel_d;
            fd_q        <= fd_d;
        end
    end

    assign rd_data    = pend_val_q;
    assign segments   = seg_q;
    assign select     = sel_q;
    assign frame_done = fd_q;

endmodule
